// File: rtl/fpmul_share_arbiter.sv
// Round-robin front end sharing one fixed-latency, non-stallable FP multiplier between two requesters.
// Define FPMUL_ARB_STATS_EN to add saturating grant/stall counters as extra output ports.
module fpmul_share_arbiter_chk (
    input logic       clk,
    input logic       rst,
    input logic       i_push,
    input logic       i_full,
    input logic [1:0] i_grant
);
    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(i_push && i_full));
    a_grant_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(i_grant));
endmodule

module fpmul_share_arbiter #(
    parameter int LAT   = 4,
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [2*W-1:0] req_a,
    input  logic [2*W-1:0] req_b,
    input  logic [1:0]     req_valid,
    output logic [1:0]     req_ready,
    output logic [W-1:0]   mul_a,
    output logic [W-1:0]   mul_b,
    input  logic [W-1:0]   mul_z,
    output logic [W-1:0]   z_data,
    output logic           z_tag,
    output logic           z_valid,
    input  logic           z_ready,
    output logic           busy
`ifdef FPMUL_ARB_STATS_EN
    ,
    output logic [31:0]    grant_cnt0,
    output logic [31:0]    grant_cnt1,
    output logic [31:0]    stall_cnt
`endif
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};

    logic [1:0]     w_grant;
    logic           w_credit;
    logic           w_issue;
    logic           w_gid;
    logic           w_push;
    logic           w_pop;

    logic           r_last;
    logic [LAT:0]   r_pipe_vld;
    logic [LAT:0]   r_pipe_tag;
    // Occupancy covers ops in flight plus results waiting in the FIFO; it is the credit budget.
    logic [CW-1:0]  r_occ;
    logic [CW-1:0]  r_cnt;
    logic [PW-1:0]  r_wr;
    logic [PW-1:0]  r_rd;
    logic [W-1:0]   r_mem [DEPTH];
    logic [DEPTH-1:0] r_mem_tag;

    assign w_credit = (r_occ < DEPTH_C);
    assign w_issue  = |w_grant;
    assign w_gid    = w_grant[1];
    assign w_push   = r_pipe_vld[LAT];
    assign w_pop    = z_valid & z_ready;

    // Round-robin grant: a lone requester wins, on a tie the one not served last wins.
    always_comb begin
        w_grant = 2'b00;
        if (w_credit && !rst) begin
            case (req_valid)
                2'b01:   w_grant = 2'b01;
                2'b10:   w_grant = 2'b10;
                2'b11:   w_grant = r_last ? 2'b01 : 2'b10;
                default: w_grant = 2'b00;
            endcase
        end else begin
            w_grant = 2'b00;
        end
    end

    // Operand registers feeding the multiplier and the round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_a  <= {W{1'b0}};
            mul_b  <= {W{1'b0}};
            r_last <= 1'b1;
        end else if (w_issue) begin
            mul_a  <= w_gid ? req_a[W +: W] : req_a[0 +: W];
            mul_b  <= w_gid ? req_b[W +: W] : req_b[0 +: W];
            r_last <= w_gid;
        end
    end

    // Tag pipe: one stage for the operand register plus LAT multiplier stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pipe_vld <= {(LAT+1){1'b0}};
            r_pipe_tag <= {(LAT+1){1'b0}};
        end else begin
            r_pipe_vld <= {r_pipe_vld[LAT-1:0], w_issue};
            r_pipe_tag <= {r_pipe_tag[LAT-1:0], w_gid};
        end
    end

    // Credit accounting: an op holds a credit from issue until its result is popped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_occ <= {CW{1'b0}};
        end else begin
            case ({w_issue, w_pop})
                2'b10:   r_occ <= r_occ + CNT_ONE;
                2'b01:   r_occ <= r_occ - CNT_ONE;
                default: r_occ <= r_occ;
            endcase
        end
    end

    // Result FIFO with tagged entries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {W{1'b0}};
            end
            r_mem_tag <= {DEPTH{1'b0}};
            r_wr      <= {PW{1'b0}};
            r_rd      <= {PW{1'b0}};
            r_cnt     <= {CW{1'b0}};
        end else begin
            if (w_push) begin
                r_mem[r_wr]     <= mul_z;
                r_mem_tag[r_wr] <= r_pipe_tag[LAT];
                r_wr            <= r_wr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd <= r_rd + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CNT_ONE;
                2'b01:   r_cnt <= r_cnt - CNT_ONE;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign req_ready = w_grant;
    assign z_data    = r_mem[r_rd];
    assign z_tag     = r_mem_tag[r_rd];
    assign z_valid   = (r_cnt != {CW{1'b0}});
    assign busy      = (r_occ != {CW{1'b0}});

`ifdef FPMUL_ARB_STATS_EN
    logic [31:0] r_gc0;
    logic [31:0] r_gc1;
    logic [31:0] r_sc;

    // Saturating handshake and stall counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gc0 <= 32'd0;
            r_gc1 <= 32'd0;
            r_sc  <= 32'd0;
        end else begin
            if (w_grant[0] && (r_gc0 != 32'hFFFF_FFFF)) begin
                r_gc0 <= r_gc0 + 32'd1;
            end
            if (w_grant[1] && (r_gc1 != 32'hFFFF_FFFF)) begin
                r_gc1 <= r_gc1 + 32'd1;
            end
            if ((|req_valid) && !w_issue && (r_sc != 32'hFFFF_FFFF)) begin
                r_sc <= r_sc + 32'd1;
            end
        end
    end

    assign grant_cnt0 = r_gc0;
    assign grant_cnt1 = r_gc1;
    assign stall_cnt  = r_sc;
`endif

    fpmul_share_arbiter_chk u_chk (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_full  (r_cnt == DEPTH_C),
        .i_grant (w_grant)
    );
endmodule

// File: tb/tb_fpmul_share_arbiter.sv
// Scoreboard bench for fpmul_share_arbiter with a behavioural FP multiplier and a credit/round-robin model.
module tb_fpmul_share_arbiter;
    localparam int LAT   = 4;
    localparam int DEPTH = 4;
    localparam int W     = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic [2*W-1:0] req_a;
    logic [2*W-1:0] req_b;
    logic [1:0]     req_valid;
    logic [1:0]     req_ready;
    logic [W-1:0]   mul_a;
    logic [W-1:0]   mul_b;
    logic [W-1:0]   mul_z;
    logic [W-1:0]   z_data;
    logic           z_tag;
    logic           z_valid;
    logic           z_ready;
    logic           busy;
`ifdef FPMUL_ARB_STATS_EN
    logic [31:0]    grant_cnt0;
    logic [31:0]    grant_cnt1;
    logic [31:0]    stall_cnt;
`endif

    fpmul_share_arbiter #(.LAT(LAT), .DEPTH(DEPTH), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_z     (mul_z),
        .z_data    (z_data),
        .z_tag     (z_tag),
        .z_valid   (z_valid),
        .z_ready   (z_ready),
        .busy      (busy)
`ifdef FPMUL_ARB_STATS_EN
        ,
        .grant_cnt0(grant_cnt0),
        .grant_cnt1(grant_cnt1),
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Truncating single-precision multiply for normal operands.
    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] m;
        logic [9:0]  e;
        m = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        e = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127;
        if (m[47]) begin
            e = e + 10'd1;
            m = m >> 1;
        end
        return {a[31] ^ b[31], e[7:0], m[45:23]};
    endfunction

    function automatic logic [31:0] rnd_fp();
        logic [7:0] e;
        e = 8'($urandom_range(100, 154));
        return {1'($urandom), e, 23'($urandom)};
    endfunction

    // External multiplier model: LAT-cycle pipeline from the registered operands.
    logic [W-1:0] fpm_pipe [LAT];
    always @(posedge clk) begin
        fpm_pipe[0] <= fp_mul(mul_a, mul_b);
        for (int k = 1; k < LAT; k++) fpm_pipe[k] <= fpm_pipe[k-1];
    end
    assign mul_z = fpm_pipe[LAT-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state.
    logic [W:0] q_exp [$];
    int         q_cyc [$];
    int         m_occ;
    logic       m_last;
    logic [1:0] m_g;
    logic       m_zv;
    logic [W:0] m_head;
    int         hs_total = 0;
    int         m_gc0, m_gc1, m_sc;

    // Monitor/model: expected grants, busy and z_valid each cycle; scoreboard pops on handshake.
    always @(negedge clk) begin
        if (rst) begin
            q_exp.delete();
            q_cyc.delete();
            m_occ  = 0;
            m_last = 1'b1;
            m_gc0  = 0;
            m_gc1  = 0;
            m_sc   = 0;
        end else begin
            m_g = 2'b00;
            if (m_occ < DEPTH) begin
                if (req_valid == 2'b11) m_g = m_last ? 2'b01 : 2'b10;
                else m_g = req_valid;
            end
            check("req_ready", req_ready, m_g);
            check("busy", busy, m_occ != 0);
            m_zv = (q_exp.size() > 0) && (cyc - q_cyc[0] >= LAT + 2);
            check("z_valid", z_valid, m_zv);
            if (z_valid && z_ready && m_zv) begin
                m_head = q_exp.pop_front();
                void'(q_cyc.pop_front());
                check("z_data", z_data, m_head[W-1:0]);
                check("z_tag", z_tag, m_head[W]);
                m_occ--;
            end
            if (req_valid != 2'b00 && m_g == 2'b00) m_sc++;
            if (m_g != 2'b00) begin
                if (m_g[1]) begin
                    q_exp.push_back({1'b1, fp_mul(req_a[W +: W], req_b[W +: W])});
                    m_gc1++;
                end else begin
                    q_exp.push_back({1'b0, fp_mul(req_a[0 +: W], req_b[0 +: W])});
                    m_gc0++;
                end
                q_cyc.push_back(cyc);
                m_last = m_g[1];
                m_occ++;
                hs_total++;
            end
        end
    end

    task automatic rnd_ops();
        req_a = {rnd_fp(), rnd_fp()};
        req_b = {rnd_fp(), rnd_fp()};
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300 && (busy || q_exp.size() > 0); i++) begin
            @(posedge clk);
            #1;
        end
        check("idle", busy, 1'b0);
    endtask

    int start;

    initial begin
        rst       = 1'b1;
        req_valid = 2'b11;
        req_a     = '0;
        req_b     = '0;
        z_ready   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", req_ready, 2'b00);
        check("rst_mul_a", mul_a, 32'd0);
        check("rst_mul_b", mul_b, 32'd0);
        check("rst_z_valid", z_valid, 1'b0);
        check("rst_z_data", z_data, 32'd0);
        check("rst_z_tag", z_tag, 1'b0);
        check("rst_busy", busy, 1'b0);
        req_valid = 2'b00;
        rst       = 1'b0;

        // Single op 1.5 * 2.0 from requester 0.
        @(posedge clk); #1;
        z_ready   = 1'b1;
        req_a     = {32'd0, 32'h3FC0_0000};
        req_b     = {32'd0, 32'h4000_0000};
        req_valid = 2'b01;
        @(posedge clk); #1;
        req_valid = 2'b00;
        wait_idle();

        // Contention: both requesters continuously valid until 8 handshakes.
        start = hs_total;
        req_valid = 2'b11;
        for (int i = 0; i < 200 && (hs_total - start) < 8; i++) begin
            rnd_ops();
            @(posedge clk); #1;
        end
        req_valid = 2'b00;
        check("contention_count", hs_total - start, 8);
        wait_idle();

        // Back-pressure: consumer stalled, requester 0 always valid.
        z_ready   = 1'b0;
        start     = hs_total;
        req_valid = 2'b01;
        for (int i = 0; i < 14; i++) begin
            rnd_ops();
            @(posedge clk); #1;
        end
        check("bp_count", hs_total - start, DEPTH);
        check("bp_blocked", req_ready, 2'b00);
        z_ready = 1'b1;
        @(posedge clk); #1;
        z_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("bp_one_more", hs_total - start, DEPTH + 1);
        req_valid = 2'b00;
        z_ready   = 1'b1;
        wait_idle();

        // Random traffic with random back-pressure.
        for (int i = 0; i < 400; i++) begin
            rnd_ops();
            req_valid = 2'($urandom);
            z_ready   = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        req_valid = 2'b00;
        z_ready   = 1'b1;
        wait_idle();

`ifdef FPMUL_ARB_STATS_EN
        check("grant_cnt0", grant_cnt0, m_gc0);
        check("grant_cnt1", grant_cnt1, m_gc1);
        check("stall_cnt", stall_cnt, m_sc);
`endif

        // Reset with three ops in flight.
        z_ready   = 1'b0;
        req_valid = 2'b01;
        for (int i = 0; i < 3; i++) begin
            rnd_ops();
            @(posedge clk); #1;
        end
        req_valid = 2'b00;
        #2 rst = 1'b1;
        @(posedge clk); #1;
        rst     = 1'b0;
        z_ready = 1'b1;
        for (int i = 0; i < LAT + 3; i++) begin
            check("post_rst_z_valid", z_valid, 1'b0);
            @(posedge clk); #1;
        end
        req_a     = {32'h4040_0000, 32'd0};
        req_b     = {32'h4000_0000, 32'd0};
        req_valid = 2'b10;
        @(posedge clk); #1;
        req_valid = 2'b00;
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
